uart_word_streamer: RTL
=======================

UART_WORD_STREAMER -- requirements
Module: uart_word_streamer

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 4, meaning bytes serialised per RAM word (1..8).
REQ-002 SHALL have parameter DEPTH, default 768, meaning words addressable in the source RAM.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 434, meaning CLOCK_50 cycles per UART bit (115200 baud).
REQ-004 SHALL have parameter MSB_FIRST, default 0, meaning 0 sends word byte [7:0] first and 1 sends the top byte first.
REQ-005 SHALL have parameter LOOP, default 0, meaning 0 is one-shot and 1 repeats the frame until STOP.
REQ-006 SHALL have port CLOCK_50  in  1  meaning the single clock, with all logic on its rising edge.
REQ-007 SHALL have port RST_N  in  1  meaning the asynchronous, active-low reset.
REQ-008 SHALL have port START  in  1  meaning a synchronous active-high request to begin a frame.
REQ-009 SHALL have port STOP  in  1  meaning a synchronous active-high request to abort or end streaming.
REQ-010 SHALL have port NUM_WORDS  in  ADDR_W+1  meaning the frame length in words, latched when START is accepted.
REQ-011 SHALL have port RD_ADDR  out  ADDR_W  meaning the source RAM read address.
REQ-012 SHALL have port RD_EN  out  1  meaning the source RAM read enable.
REQ-013 SHALL have port RD_DATA  in  8*BYTES_PER_WORD  meaning RAM read data, valid exactly 1 cycle after RD_EN.
REQ-014 SHALL have port UART_TXD  out  1  meaning the serial line, idle high.
REQ-015 SHALL have port BUSY  out  1  meaning high in every state other than IDLE.
REQ-016 SHALL have port DONE  out  1  meaning a 1-cycle pulse when a pass completes normally.
REQ-017 SHALL have port WORD_CNT  out  ADDR_W+1  meaning the number of words fully transmitted in the current pass.

Function
REQ-018 SHALL define ADDR_W as clog2(DEPTH).
REQ-019 SHALL use states IDLE, FETCH, CAPTURE, SEND, WAIT_TX and FINISH.
REQ-020 SHALL, in IDLE with START=1 and STOP=0, latch min(NUM_WORDS, DEPTH), set RD_ADDR=0 and WORD_CNT=0, and go to FETCH.
REQ-021 SHALL, when the latched length is 0, go from IDLE to FINISH, pulse DONE, and produce no UART activity.
REQ-022 SHALL, in FETCH, assert RD_EN for exactly 1 cycle and then go to CAPTURE.
REQ-023 SHALL, in CAPTURE, load RD_DATA into the word shift register, clear the byte index, and go to SEND.
REQ-024 SHALL, in SEND, issue a 1-cycle byte start to the serialiser and then go to WAIT_TX.
REQ-025 SHALL, in WAIT_TX when the serialiser completes its stop bit, go to SEND if bytes remain, otherwise increment WORD_CNT and RD_ADDR and go to FETCH or FINISH.
REQ-026 SHALL frame each byte as 8N1: start bit 0, data LSB first, stop bit 1, each bit lasting exactly CLKS_PER_BIT cycles, for 10*CLKS_PER_BIT cycles per byte.
REQ-027 SHALL keep the idle-high gap between bytes of one word to exactly 1 cycle.
REQ-028 SHALL keep the idle-high gap between words to exactly 3 cycles.
REQ-029 SHALL, in FINISH, pulse DONE for 1 cycle and then go to IDLE, or with LOOP=1 and STOP=0 reset RD_ADDR and WORD_CNT to 0 and go to FETCH.
REQ-030 SHALL, when STOP is asserted during SEND or WAIT_TX, complete the current byte including its stop bit and then go to IDLE without DONE.
REQ-031 SHALL, when STOP is asserted in FETCH or CAPTURE, go to IDLE on the next cycle.
REQ-032 SHALL never truncate a frame on UART_TXD.
REQ-033 SHALL ignore START while BUSY=1.
REQ-034 SHALL, when START and STOP are both high in IDLE, remain in IDLE because STOP wins.
REQ-035 SHALL, on RD_ADDR reaching DEPTH-1 and incrementing, wrap it to 0.
REQ-036 SHALL keep WORD_CNT saturating at the latched length.

Reset
REQ-037 SHALL, with RST_N=0, asynchronously force the IDLE state.
REQ-038 SHALL, with RST_N=0, force UART_TXD=1, BUSY=0, DONE=0, RD_EN=0, RD_ADDR=0 and WORD_CNT=0.
REQ-039 SHALL clear the serialiser bit counter and baud counter on reset.
REQ-040 SHALL permit a reset mid-byte to cut the frame, returning the line to high immediately.
REQ-041 SHALL release from reset synchronously to CLOCK_50 and accept START on the first cycle after release.

Structure
REQ-042 SHALL place the state encoding enum, the 8N1 frame-length constant (10) and the ADDR_W helper function in the shared package comm_pkg.
REQ-043 SHALL implement byte serialisation in one sub-module uart_tx_byte, with ports CLOCK_50, RST_N, GO, DATA[7:0], TXD and DONE, parameterised by CLKS_PER_BIT.

Verification
REQ-044 SHALL cover: CLKS_PER_BIT=4, NUM_WORDS=2, RAM={0x44332211, 0x88776655}, START -> bytes 11 22 33 44 55 66 77 88 on TXD, one DONE pulse, WORD_CNT=2.
REQ-045 SHALL cover: MSB_FIRST=1 with the same data -> bytes 44 33 22 11 88 77 66 55.
REQ-046 SHALL cover: NUM_WORDS=0, START -> DONE on the 2nd cycle, TXD constantly 1, BUSY high for 1 cycle.
REQ-047 SHALL cover: STOP asserted mid-bit 3 of byte 2 -> byte 2 completes with its stop bit, no byte 3, no DONE, IDLE one cycle later.
REQ-048 SHALL cover: LOOP=1, NUM_WORDS=1, run three passes then STOP -> 3 DONE pulses, RD_ADDR returns to 0 each pass, clean halt.
REQ-049 SHALL cover: RST_N low mid start bit -> TXD=1 within the same cycle, all outputs at reset values, and a new START accepted after release.

Source files
------------

// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared state encoding, 8N1 frame length and address-width helper
package comm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT_TX,
    ST_FINISH
  } state_e;

  // start bit + 8 data bits + stop bit
  localparam int FRAME_BITS = 10;

  // ceil(log2(depth)); held at 1 so a single-word RAM still gets a legal address port
  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_word_streamer_if.sv
// rtl/uart_word_streamer_if.sv - source RAM read bus between streamer and RAM
interface uart_word_streamer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser, DONE marks the last cycle of the stop bit
module uart_tx_byte
  import comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       GO,
  input  logic [7:0] DATA,
  output logic       TXD,
  output logic       DONE
);
  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [3:0]            bit_q;
  logic                  busy_q;

  // The line is the LSB of the frame shifter; an all-ones shifter is the idle level.
  assign TXD  = frame_q[0];
  // Combinational so the caller can launch the next byte with a single idle cycle.
  assign DONE = busy_q && (baud_q == BAUD_LAST) && (bit_q == BIT_LAST);

  // Load the frame on GO, then shift one bit every CLKS_PER_BIT cycles, back-filling ones.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      frame_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!busy_q) begin
      if (GO) begin
        frame_q <= {1'b1, DATA, 1'b0};
        baud_q  <= '0;
        bit_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_q  <= '0;
      frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
      if (bit_q == BIT_LAST) begin
        busy_q <= 1'b0;
        bit_q  <= '0;
      end else begin
        bit_q <= bit_q + 4'd1;
      end
    end else begin
      baud_q <= baud_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_word_streamer.sv
// rtl/uart_word_streamer.sv - streams RAM words out of a UART, byte by byte
module uart_word_streamer
  import comm_pkg::*;
#(
  parameter int  BYTES_PER_WORD = 4,
  parameter int  DEPTH          = 768,
  parameter int  CLKS_PER_BIT   = 434,
  parameter int  MSB_FIRST      = 0,
  parameter int  LOOP           = 0,
  localparam int ADDR_W         = addr_w(DEPTH)
) (
  input  logic                          CLOCK_50,
  input  logic                          RST_N,
  input  logic                          START,
  input  logic                          STOP,
  input  logic [ADDR_W:0]               NUM_WORDS,
  output logic [ADDR_W-1:0]             RD_ADDR,
  output logic                          RD_EN,
  input  logic [8*BYTES_PER_WORD-1:0]   RD_DATA,
  output logic                          UART_TXD,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [ADDR_W:0]               WORD_CNT
);
  localparam int                DATA_W    = 8 * BYTES_PER_WORD;
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  state_e              state_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_en_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic [DATA_W-1:0]   word_q;
  logic [3:0]          byte_idx_q;
  logic                go_q;
  logic                done_q;
  logic                stop_pend_q;

  logic [ADDR_W:0]     len_sel;
  logic [ADDR_W:0]     cnt_inc;
  logic [7:0]          tx_data;
  logic [DATA_W-1:0]   word_next;
  logic                tx_done;

  assign len_sel   = (NUM_WORDS > DEPTH_W) ? DEPTH_W : NUM_WORDS;
  assign cnt_inc   = word_cnt_q + 1'b1;
  // The outgoing byte always sits at one end of the word register; it is shifted after each byte.
  assign tx_data   = (MSB_FIRST != 0) ? word_q[DATA_W-1 -: 8] : word_q[7:0];
  assign word_next = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .GO       (go_q),
    .DATA     (tx_data),
    .TXD      (UART_TXD),
    .DONE     (tx_done)
  );

  assign RD_ADDR  = rd_addr_q;
  assign RD_EN    = rd_en_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign WORD_CNT = word_cnt_q;

  // Main sequencer; RD_EN, GO and DONE are set on entry to the state that owns them.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      go_q        <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          stop_pend_q <= 1'b0;
          if (START && !STOP) begin
            len_q      <= len_sel;
            rd_addr_q  <= '0;
            word_cnt_q <= '0;
            if (len_sel == '0) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state_q <= STOP ? ST_IDLE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (STOP) begin
            state_q <= ST_IDLE;
          end else begin
            word_q     <= RD_DATA;
            byte_idx_q <= '0;
            go_q       <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // The byte has been launched; a STOP here only takes effect once it is on the wire.
          if (STOP) stop_pend_q <= 1'b1;
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (STOP) stop_pend_q <= 1'b1;
          if (tx_done) begin
            if (STOP || stop_pend_q) begin
              state_q <= ST_IDLE;
            end else if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 4'd1;
              word_q     <= word_next;
              go_q       <= 1'b1;
              state_q    <= ST_SEND;
            end else begin
              word_cnt_q <= (word_cnt_q < len_q) ? cnt_inc : word_cnt_q;
              rd_addr_q  <= (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
              if (cnt_inc >= len_q) begin
                state_q <= ST_FINISH;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_FETCH;
                rd_en_q <= 1'b1;
              end
            end
          end
        end
        ST_FINISH: begin
          if ((LOOP != 0) && !STOP) begin
            rd_addr_q  <= '0;
            word_cnt_q <= '0;
            rd_en_q    <= 1'b1;
            state_q    <= ST_FETCH;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
